// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment definitions for the hex encoder and the capture decoder.
//   seg_t      : segment bus {g,f,e,d,c,b,a}, active-low
//   SEG_HEX    : glyph for each hex digit 0..F
//   SEG_BLANK  : all segments off
//   dig_res_t  : decoded per-digit result {val, vld, blk, err}
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] val;
        logic       vld;
        logic       blk;
        logic       err;
    } dig_res_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational seven-segment pattern classifier.
//   pat : segment pattern, active-low {g..a}
//   res : {val, vld, blk, err}; val is only meaningful when vld=1 (0 otherwise)
module seg_pattern_decode
    import seg_pkg::*;
(
    input  seg_t     pat,
    output dig_res_t res
);

    always_comb begin
        res = '{val: 4'd0, vld: 1'b0, blk: 1'b0, err: 1'b1};
        if (pat == SEG_BLANK) begin
            res.blk = 1'b1;
            res.err = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_HEX[i]) begin
                res.val = i[3:0];
                res.vld = 1'b1;
                res.err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: watches a multiplexed active-low seven-segment bus and recovers the
// hex value shown on each digit.
//   clk, reset : system clock, synchronous active-high reset
//   seg, an    : segment lines and anode enables (active-low, asynchronous to clk)
//   digit_val  : decoded value per digit, digit k at [4k+3:4k]
//   digit_vld  : digit k holds a legal hex glyph
//   digit_blk  : digit k last captured all-off
//   digit_err  : digit k last captured an illegal pattern
//   upd/upd_idx: one-cycle pulse when a digit's stored result changes, with its index
//   bus_err    : one-cycle pulse when more than one anode is active
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_vld,
    output logic [NUM_DIGITS-1:0]   digit_blk,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    bus_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    seg_t                  seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

    seg_t                  last_pat;
    logic [2:0]            last_idx;
    logic [CW-1:0]         cnt;
    logic                  done;

    dig_res_t              res_q [NUM_DIGITS];

    // Active-anode census on the synced bus
    logic [3:0] n_act;
    logic [2:0] act_idx;

    always_comb begin
        n_act   = 4'd0;
        act_idx = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an_s2[k]) begin
                n_act   = n_act + 4'd1;
                act_idx = 3'(k);
            end
        end
    end

    dig_res_t dec;

    seg_pattern_decode u_dec (
        .pat (seg_s2),
        .res (dec)
    );

    // Stored result of the digit currently under the anode
    dig_res_t sel_q;

    always_comb begin
        sel_q = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (act_idx == 3'(k)) sel_q = res_q[k];
    end

    // Blank and illegal patterns keep the last legal value
    dig_res_t cur;

    always_comb begin
        cur     = dec;
        cur.val = dec.vld ? dec.val : sel_q.val;
    end

    // cnt != 0 means the previous cycle was itself a single-anode cycle
    logic same, capture, changed;

    assign same    = (cnt != '0) && (act_idx == last_idx) && (seg_s2 == last_pat);
    // Capture on the edge where the counter steps up to STABLE_CYCLES
    assign capture = (n_act == 4'd1) && same && !done &&
                     (cnt == CW'(STABLE_CYCLES - 1));
    assign changed = (cur != sel_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1   <= SEG_BLANK;
            seg_s2   <= SEG_BLANK;
            an_s1    <= '1;
            an_s2    <= '1;
            last_pat <= SEG_BLANK;
            last_idx <= 3'd0;
            cnt      <= '0;
            done     <= 1'b0;
            upd      <= 1'b0;
            upd_idx  <= 3'd0;
            bus_err  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) res_q[k] <= '0;
        end else begin
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            an_s1    <= an;
            an_s2    <= an_s1;
            last_pat <= seg_s2;
            last_idx <= act_idx;
            upd      <= 1'b0;
            bus_err  <= 1'b0;

            if (n_act == 4'd0) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (n_act == 4'd1) begin
                if (same) begin
                    if (cnt < CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
                end else begin
                    cnt  <= CW'(1);
                    done <= 1'b0;
                end
                if (capture) begin
                    done <= 1'b1;
                    if (changed) begin
                        upd     <= 1'b1;
                        upd_idx <= act_idx;
                    end
                end
            end else begin
                bus_err <= 1'b1;
                cnt     <= '0;
                done    <= 1'b0;
            end

            for (int k = 0; k < NUM_DIGITS; k++)
                if (capture && (act_idx == 3'(k))) res_q[k] <= cur;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_out
        assign digit_val[4*k +: 4] = res_q[k].val;
        assign digit_vld[k]        = res_q[k].vld;
        assign digit_blk[k]        = res_q[k].blk;
        assign digit_err[k]        = res_q[k].err;
    end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// tb_seg_capture_decoder: table-driven bench with an upd scoreboard for seg_capture_decoder
// (NUM_DIGITS=2, STABLE_CYCLES=4).
module tb_seg_capture_decoder;

    localparam int ND = 2;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] digit_val;
    logic [ND-1:0] digit_vld, digit_blk, digit_err;
    logic          upd;
    logic [2:0]    upd_idx;
    logic          bus_err;

    seg_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .an        (an),
        .digit_val (digit_val),
        .digit_vld (digit_vld),
        .digit_blk (digit_blk),
        .digit_err (digit_err),
        .upd       (upd),
        .upd_idx   (upd_idx),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        int         cyc;
        logic [7:0] e_val;
        logic [1:0] e_vld;
        logic [1:0] e_blk;
        logic [1:0] e_err;
        int         e_upd;
        int         e_berr;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] val;
        logic       vld;
        logic       blk;
        logic       err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int upd_cnt = 0, berr_cnt = 0;
    int upd_snap = 0, berr_snap = 0;

    logic [6:0] hex_tbl [16];
    logic [3:0] m_val [ND];
    logic       m_vld [ND], m_blk [ND], m_err [ND];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < ND; k++) begin
            m_val[k] = 4'd0; m_vld[k] = 1'b0; m_blk[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    // Predict the capture of a whole dwell and queue an upd when the result changes
    task automatic model_dwell(input logic [1:0] a, input logic [6:0] s, input int cyc);
        int   k;
        exp_t e;
        k = (a == 2'b10) ? 0 : (a == 2'b01) ? 1 : -1;
        if (k < 0 || cyc < SC) return;
        e.idx = 3'(k);
        e.val = m_val[k];
        e.vld = 1'b0;
        e.blk = (s == 7'h7F);
        e.err = !e.blk;
        for (int h = 0; h < 16; h++)
            if (s == hex_tbl[h]) begin
                e.val = 4'(h); e.vld = 1'b1; e.err = 1'b0;
            end
        if ({e.val, e.vld, e.blk, e.err} != {m_val[k], m_vld[k], m_blk[k], m_err[k]}) begin
            sb.push_back(e);
            m_val[k] = e.val; m_vld[k] = e.vld; m_blk[k] = e.blk; m_err[k] = e.err;
        end
    endtask

    task automatic add(input logic [1:0] a, input logic [6:0] s, input int cyc,
                       input logic [7:0] v, input logic [1:0] vl, input logic [1:0] bk,
                       input logic [1:0] er, input int u, input int b);
        tbl.push_back('{a, s, cyc, v, vl, bk, er, u, b});
    endtask

    task automatic check_row(input int j);
        @(negedge clk);
        #1;
        chk($sformatf("row%0d_outputs", j), {18'd0, digit_val, digit_vld, digit_blk, digit_err},
            {18'd0, tbl[j].e_val, tbl[j].e_vld, tbl[j].e_blk, tbl[j].e_err});
        chk($sformatf("row%0d_upd_count", j), upd_cnt - upd_snap, tbl[j].e_upd);
        chk($sformatf("row%0d_bus_err_count", j), berr_cnt - berr_snap, tbl[j].e_berr);
        upd_snap  = upd_cnt;
        berr_snap = berr_cnt;
    endtask

    // Scoreboard: every upd pulse must match the oldest predicted change
    always @(negedge clk) begin
        if (bus_err) berr_cnt++;
        if (upd) begin
            int   i;
            exp_t e;
            upd_cnt++;
            i = int'(upd_idx);
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL upd_unexpected idx=%0d val=%h", upd_idx, digit_val);
            end else begin
                e = sb.pop_front();
                if ({upd_idx, digit_val[4*i +: 4], digit_vld[i], digit_blk[i], digit_err[i]} !==
                    {e.idx, e.val, e.vld, e.blk, e.err}) begin
                    fails++;
                    $display("FAIL upd_event got idx=%0d val=%h v/b/e=%b%b%b exp idx=%0d val=%h v/b/e=%b%b%b",
                             upd_idx, digit_val[4*i +: 4], digit_vld[i], digit_blk[i], digit_err[i],
                             e.idx, e.val, e.vld, e.blk, e.err);
                end
            end
        end
    end

    initial begin
        int seen_at;

        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_clear();

        //  an     seg         cyc  val    vld    blk    err   upd berr
        add(2'b10, 7'b0100100, 10, 8'h02, 2'b01, 2'b00, 2'b00, 1, 0);
        add(2'b11, 7'b1111111,  3, 8'h02, 2'b01, 2'b00, 2'b00, 0, 0);
        add(2'b10, 7'b0100100,  6, 8'h02, 2'b01, 2'b00, 2'b00, 0, 0);
        add(2'b10, 7'b0011000,  6, 8'h09, 2'b01, 2'b00, 2'b00, 1, 0);
        add(2'b01, 7'b0000011,  6, 8'hB9, 2'b11, 2'b00, 2'b00, 1, 0);
        for (int r = 0; r < 3; r++) begin
            add(2'b10, 7'b0011000, 6, 8'hB9, 2'b11, 2'b00, 2'b00, 0, 0);
            add(2'b01, 7'b0000011, 6, 8'hB9, 2'b11, 2'b00, 2'b00, 0, 0);
        end
        add(2'b10, 7'b0000000,  3, 8'hB9, 2'b11, 2'b00, 2'b00, 0, 0);
        add(2'b10, 7'b1111001,  4, 8'hB1, 2'b11, 2'b00, 2'b00, 1, 0);
        add(2'b00, 7'b0000000,  5, 8'hB1, 2'b11, 2'b00, 2'b00, 0, 5);
        add(2'b01, 7'b1111111,  6, 8'hB1, 2'b01, 2'b10, 2'b00, 1, 0);
        add(2'b01, 7'b0101010,  6, 8'hB1, 2'b01, 2'b00, 2'b10, 1, 0);
        add(2'b01, 7'b0000011,  6, 8'hB1, 2'b11, 2'b00, 2'b00, 1, 0);
        add(2'b11, 7'b1111111,  4, 8'hB1, 2'b11, 2'b00, 2'b00, 0, 0);

        // Reset state
        reset = 1'b1; an = '1; seg = 7'h7F;
        repeat (3) step();
        chk("reset_outputs", {18'd0, digit_val, digit_vld, digit_blk, digit_err},  32'd0);
        chk("reset_pulses", {29'd0, upd, upd_idx != 3'd0, bus_err}, 32'd0);
        reset = 1'b0;
        step();
        upd_snap = upd_cnt; berr_snap = berr_cnt;

        // Table rows; row i is checked two cycles into row i+1, once its synced tail is consumed
        for (int i = 0; i < tbl.size(); i++) begin
            an = tbl[i].an; seg = tbl[i].seg;
            model_dwell(tbl[i].an, tbl[i].seg, tbl[i].cyc);
            for (int c = 0; c < tbl[i].cyc; c++) begin
                step();
                if (c == 1 && i > 0) check_row(i - 1);
            end
        end
        an = '1; seg = 7'h7F;
        step(); step();
        check_row(tbl.size() - 1);
        repeat (4) step();

        // Reset mid-dwell: counter at 3 when reset is sampled
        an = 2'b01; seg = 7'b1000000;
        repeat (5) step();
        chk("middwell_no_capture", upd_cnt - upd_snap, 0);
        reset = 1'b1;
        step();
        chk("middwell_reset_outputs", {18'd0, digit_val, digit_vld, digit_blk, digit_err}, 32'd0);
        chk("middwell_reset_pulses", {29'd0, upd, upd_idx != 3'd0, bus_err}, 32'd0);
        reset = 1'b0;
        model_clear();
        model_dwell(2'b01, 7'b1000000, SC);
        // Synchronizers refill in 2 cycles, then a fresh dwell of SC cycles
        seen_at = 0;
        for (int s = 1; s <= 10 && seen_at == 0; s++) begin
            step();
            if (upd) seen_at = s;
        end
        chk("middwell_restart_latency", seen_at, 2 + SC);
        @(negedge clk); #1;
        chk("middwell_result", {24'd0, digit_val, digit_vld}, {24'd0, 8'h00, 2'b10});

        an = '1; seg = 7'h7F;
        repeat (4) step();
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
